// File: rtl/time_entry.sv
// rtl/time_entry.sv - keypad M:SS entry buffer with validation and counter load strobe
module time_entry #(
  parameter int SEC_TENS_MAX = 5,
  parameter int MAX_DIGITS   = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       clear,
  input  logic       busy,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       loadn,
  output logic [1:0] digit_count,
  output logic       entry_err,
  output logic       locked
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    LOAD   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [3:0] TENS_MAX   = 4'(SEC_TENS_MAX);
  localparam logic [1:0] FULL_COUNT = 2'(MAX_DIGITS);

  state_t     state_q, state_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [1:0] digit_count_q, digit_count_d;
  logic       loadn_q, loadn_d;
  logic       entry_err_q, entry_err_d;
  logic       locked_q, locked_d;
  logic       busy_seen_q, busy_seen_d;

  // Next-state logic: clear beats start beats key_valid; buffer frozen from start to end of cook.
  always_comb begin
    state_d       = state_q;
    sec_ones_d    = sec_ones_q;
    sec_tens_d    = sec_tens_q;
    min_ones_d    = min_ones_q;
    digit_count_d = digit_count_q;
    loadn_d       = 1'b1;
    entry_err_d   = 1'b0;
    locked_d      = locked_q;
    busy_seen_d   = busy_seen_q;

    if (clear) begin
      state_d       = IDLE;
      sec_ones_d    = 4'd0;
      sec_tens_d    = 4'd0;
      min_ones_d    = 4'd0;
      digit_count_d = 2'd0;
      locked_d      = 1'b0;
      busy_seen_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, ENTRY: begin
          if (start) begin
            // A key arriving with start is dropped; start sees the old buffer.
            if (state_q == ENTRY) begin
              if (sec_tens_q > TENS_MAX) begin
                entry_err_d = 1'b1;
              end else begin
                state_d  = LOAD;
                loadn_d  = 1'b0;
                locked_d = 1'b1;
              end
            end
          end else if (key_valid) begin
            if (key_digit > 4'd9 || digit_count_q == FULL_COUNT) begin
              entry_err_d = 1'b1;
            end else begin
              min_ones_d    = sec_tens_q;
              sec_tens_d    = sec_ones_q;
              sec_ones_d    = key_digit;
              digit_count_d = digit_count_q + 2'd1;
              state_d       = ENTRY;
            end
          end
        end
        LOAD: begin
          state_d = LOCKED;
        end
        LOCKED: begin
          // Completion needs a busy high seen first, so a late-starting countdown is not missed.
          if (busy_seen_q && !busy) begin
            state_d       = IDLE;
            sec_ones_d    = 4'd0;
            sec_tens_d    = 4'd0;
            min_ones_d    = 4'd0;
            digit_count_d = 2'd0;
            locked_d      = 1'b0;
            busy_seen_d   = 1'b0;
          end else if (busy) begin
            busy_seen_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      sec_ones_q    <= 4'd0;
      sec_tens_q    <= 4'd0;
      min_ones_q    <= 4'd0;
      digit_count_q <= 2'd0;
      loadn_q       <= 1'b1;
      entry_err_q   <= 1'b0;
      locked_q      <= 1'b0;
      busy_seen_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sec_ones_q    <= sec_ones_d;
      sec_tens_q    <= sec_tens_d;
      min_ones_q    <= min_ones_d;
      digit_count_q <= digit_count_d;
      loadn_q       <= loadn_d;
      entry_err_q   <= entry_err_d;
      locked_q      <= locked_d;
      busy_seen_q   <= busy_seen_d;
    end
  end

  assign sec_ones    = sec_ones_q;
  assign sec_tens    = sec_tens_q;
  assign min_ones    = min_ones_q;
  assign loadn       = loadn_q;
  assign digit_count = digit_count_q;
  assign entry_err   = entry_err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_time_entry.sv
// tb/tb_time_entry.sv - scoreboard bench for time_entry against a digit-list reference model
module tb_time_entry;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       busy = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic       loadn;
  logic [1:0] digit_count;
  logic       entry_err;
  logic       locked;

  always #5 clk = ~clk;

  time_entry #(.SEC_TENS_MAX(5), .MAX_DIGITS(3)) dut (
    .clk(clk), .rstn(rstn), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .clear(clear), .busy(busy),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .loadn(loadn), .digit_count(digit_count), .entry_err(entry_err), .locked(locked)
  );

  typedef struct packed {
    logic [3:0] so;
    logic [3:0] st;
    logic [3:0] mo;
    logic [1:0] cnt;
    logic       ldn;
    logic       err;
    logic       lck;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: the entered digits as a list (newest last) plus cook phase flags.
  int m_digits[$];
  bit m_loading = 0;
  bit m_cooking = 0;
  bit m_saw_busy = 0;

  function automatic int m_digit(int back);
    int n = m_digits.size();
    return (n > back) ? m_digits[n - 1 - back] : 0;
  endfunction

  function automatic exp_t model_out(bit err, bit ldn);
    exp_t e;
    e.so  = 4'(m_digit(0));
    e.st  = 4'(m_digit(1));
    e.mo  = 4'(m_digit(2));
    e.cnt = 2'(m_digits.size());
    e.ldn = ldn;
    e.err = err;
    e.lck = m_loading || m_cooking;
    return e;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_loading  = 0;
    m_cooking  = 0;
    m_saw_busy = 0;
  endtask

  task automatic model_step(input bit kv, input int kd, input bit st, input bit cl, input bit bz);
    bit err = 0;
    bit ldn = 1;
    if (cl) begin
      model_reset();
    end else if (m_loading) begin
      m_loading = 0;
      m_cooking = 1;
    end else if (m_cooking) begin
      if (m_saw_busy && !bz) model_reset();
      else if (bz) m_saw_busy = 1;
    end else if (st) begin
      if (m_digits.size() > 0) begin
        if (m_digit(1) > 5) err = 1;
        else begin
          m_loading = 1;
          ldn = 0;
        end
      end
    end else if (kv) begin
      if (kd > 9 || m_digits.size() >= 3) err = 1;
      else m_digits.push_back(kd);
    end
    sb_q.push_back(model_out(err, ldn));
  endtask

  task automatic direct(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus, driven on the falling edge, with its expectation queued.
  task automatic cyc(input bit kv, input int kd, input bit st, input bit cl, input bit bz);
    @(negedge clk);
    key_valid = kv;
    key_digit = 4'(kd);
    start     = st;
    clear     = cl;
    busy      = bz;
    model_step(kv, kd, st, cl, bz);
  endtask

  task automatic key(input int kd);
    cyc(1, kd, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every registered output set against the oldest queued expectation.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = '{sec_ones, sec_tens, min_ones, digit_count, loadn, entry_err, locked};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got so=%0d st=%0d mo=%0d cnt=%0d loadn=%b err=%b locked=%b expected so=%0d st=%0d mo=%0d cnt=%0d loadn=%b err=%b locked=%b",
                   $time, a.so, a.st, a.mo, a.cnt, a.ldn, a.err, a.lck,
                   e.so, e.st, e.mo, e.cnt, e.ldn, e.err, e.lck);
        end
      end
    end
  end

  initial begin
    bit rb;
    int rk;
    int drain;

    repeat (2) @(negedge clk);
    direct("reset_loadn", loadn, 1);
    direct("reset_locked", locked, 0);
    direct("reset_count", digit_count, 0);
    direct("reset_err", entry_err, 0);
    direct("reset_digits", {min_ones, sec_tens, sec_ones}, 0);
    rstn = 1'b1;

    // Three digits shift in right to left.
    key(1); key(3); key(0);
    @(posedge clk); #2;
    direct("entry_min", min_ones, 1);
    direct("entry_tens", sec_tens, 3);
    direct("entry_ones", sec_ones, 0);
    direct("entry_count", digit_count, 3);
    cyc(0, 0, 0, 1, 0);

    // Legal start, full cook cycle with busy.
    key(4); key(5);
    cyc(0, 0, 1, 0, 0);
    @(posedge clk); #2;
    direct("load_strobe", loadn, 0);
    direct("load_tens", sec_tens, 4);
    direct("load_locked", locked, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

    // Fourth digit discarded.
    key(7); key(2); key(1); key(9);
    cyc(0, 0, 0, 1, 0);

    // Illegal seconds tens on start, then clear.
    key(8); key(0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);

    // Non-BCD key and empty start.
    key(12);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Key coincident with start is dropped silently.
    key(3);
    cyc(1, 6, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // Keys and start ignored while locked, then abort.
    key(1); key(2);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 5, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);

    // Asynchronous reset during the load cycle.
    key(4); key(5);
    cyc(0, 0, 1, 0, 0);
    @(negedge clk);
    key_valid = 0; start = 0; clear = 0; busy = 0;
    direct("pre_reset_loadn", loadn, 0);
    rstn = 1'b0;
    #1;
    direct("async_loadn", loadn, 1);
    direct("async_locked", locked, 0);
    direct("async_count", digit_count, 0);
    direct("async_digits", {min_ones, sec_tens, sec_ones}, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic.
    rb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      rk = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 9) : $urandom_range(10, 15);
      cyc($urandom_range(0, 9) < 3, rk, $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 3, rb);
    end
    cyc(0, 0, 0, 0, 0);

    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (sb_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/time_entry.md
Name: time_entry

Overview:
- Keypad time-entry stage directly upstream of the timer digit counters (mod-10 seconds units, mod-6 seconds tens, mod-10 minutes).
- Collects BCD digits from the keypad decoder right-to-left into an M:SS buffer and validates the entered time.
- On start, drives the counters' parallel-load bus and issues a one-cycle active-low load strobe.
- Holds the buffer locked until the cook cycle ends or is aborted.

Parameters:
- SEC_TENS_MAX, default 5: largest legal seconds-tens digit, matching the mod-6 counter.
- MAX_DIGITS, default 3: number of digits the buffer accepts. Fixed at 3 in this revision; any other value is unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- key_valid  input  1  one-cycle strobe: key_digit is valid.
- key_digit  input  4  BCD digit from keypad decoder.
- start  input  1  one-cycle start request.
- clear  input  1  one-cycle clear/abort request.
- busy  input  1  high while the timer counters are counting down.
- sec_ones  output  4  load data for the seconds-units counter.
- sec_tens  output  4  load data for the seconds-tens counter.
- min_ones  output  4  load data for the minutes counter.
- loadn  output  1  active-low load strobe to all three counters.
- digit_count  output  2  number of digits entered, 0..3.
- entry_err  output  1  one-cycle pulse on a rejected key or start.
- locked  output  1  high while in LOAD or LOCKED.

Behaviour:
- Reset is asynchronous on rstn low. Reset values: sec_ones = sec_tens = min_ones = 0, digit_count = 0, loadn = 1, entry_err = 0, locked = 0, state = IDLE.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - IDLE: digit_count = 0.
  - ENTRY: 1 to 3 digits held.
  - LOAD: exactly one cycle.
  - LOCKED: cook cycle in progress.
- Priority within a cycle: clear > start > key_valid.
- Digit entry (IDLE/ENTRY, key_valid = 1, start = 0, clear = 0):
  - key_digit <= 9 and digit_count < 3: min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= key_digit; digit_count increments; state becomes ENTRY.
  - key_digit > 9: buffer and count unchanged; entry_err pulses.
  - digit_count == 3: digit discarded; entry_err pulses.
- Start in IDLE with digit_count == 0: ignored, no error.
- Start in ENTRY:
  - sec_tens > SEC_TENS_MAX: entry_err pulses; buffer kept; state stays ENTRY so the user can clear.
  - Otherwise: state goes to LOAD. loadn = 0 for exactly the cycle after start is sampled. locked = 1 from that cycle.
- key_valid coincident with start: the digit is discarded with no error pulse, and start is processed against the buffer as it was before that cycle.
- LOAD -> LOCKED unconditionally after one cycle; loadn returns to 1.
- sec_ones, sec_tens and min_ones remain stable from the start cycle through the end of LOCKED.
- LOCKED:
  - key_valid and start are ignored, with no error pulse.
  - An internal busy_seen flag sets when busy = 1.
  - Exit to IDLE on the first cycle with busy_seen = 1 and busy = 0. This is normal completion.
- Exiting LOCKED (completion or clear): buffer cleared to 0, digit_count = 0, locked = 0, busy_seen = 0.
- clear in IDLE, ENTRY, LOAD or LOCKED: next state IDLE, buffer and count zeroed, loadn = 1 next cycle. In LOCKED this acts as abort.
- busy high while in IDLE/ENTRY has no effect.
- Reset mid-LOAD: loadn returns to 1 immediately, asynchronously.
- digit_count never wraps; it saturates at 3 by discard.

Test Plan:
- Reset, then key 1, 3, 0 (one strobe each, 2 cycles apart) -> min_ones = 1, sec_tens = 3, sec_ones = 0, digit_count = 3, locked = 0, loadn = 1.
- Keys 4, 5, then start -> next cycle loadn = 0 for exactly one cycle with sec_tens = 4, sec_ones = 5, min_ones = 0; locked = 1. Then busy 1 for 10 cycles then 0 -> IDLE, all digits 0, locked = 0.
- Keys 7, 2, 1 (sec_tens = 2 after shift is legal), then key 9 -> fourth digit discarded, entry_err pulses once, buffer stays 7:21.
- Keys 8, 0 then start (sec_tens = 8 > 5) -> entry_err pulse, loadn stays 1, state ENTRY. Then clear -> all digits 0, digit_count 0.
- key_digit = 12 strobed -> entry_err pulse, no shift. Start with digit_count = 0 -> no loadn, no error.
- In LOCKED with busy = 1: key 5 and start ignored; clear -> IDLE next cycle, digits zeroed. Separately, rstn low during the LOAD cycle -> loadn = 1 and all outputs at reset values immediately.
